pulse_period_meter: RTL

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

---
 rtl/pulse_period_meter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the spacing, in Origin_Clock cycles, between successive rising
// edges of a single-clock-domain pulse. The first edge after arming only
// starts the count. Each later edge captures the elapsed count and hands it
// to a consumer through a valid/ready pair. Sticky flags record counter
// saturation without an edge (timeout) and results dropped because the
// consumer had not taken the previous one (overrun).
//
// Ports:
//   Origin_Clock  in   single clock, rising edge
//   reset         in   synchronous, active-high
//   pulse         in   signal under measurement (only rising edges count)
//   enable        in   1 = measure, 0 = idle
//   clear_flags   in   one-cycle request to clear timeout/overrun
//   period        out  [WIDTH] last captured period
//   period_valid  out  period holds an unconsumed result
//   period_ready  in   consumer accepts period this cycle
//   locked        out  high while measuring (state MEASURE)
//   timeout       out  sticky, counter saturated without an edge
//   overrun       out  sticky, a result was dropped

module pulse_period_meter #(
  parameter int WIDTH = 24
) (
  input  logic             Origin_Clock,
  input  logic             reset,
  input  logic             pulse,
  input  logic             enable,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             locked,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } MeterState;

  localparam logic [WIDTH-1:0] CountMax = '1;
  localparam logic [WIDTH-1:0] CountOne = {{(WIDTH-1){1'b0}}, 1'b1};

  MeterState        r_state;
  MeterState        w_stateNext;
  logic             r_pulseQ;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_countNext;
  logic [WIDTH-1:0] r_period;
  logic             r_periodValid;
  logic             r_timeout;
  logic             r_overrun;
  logic             w_rise;
  logic             w_capture;
  logic             w_timeoutEvent;
  logic             w_transfer;
  logic             w_overrunEvent;
  logic             w_load;

  // A level held high for many cycles is a single event, so only the
  // low-to-high transition against last cycle's sample is treated as an edge.
  assign w_rise = pulse & ~r_pulseQ;

  // Handshake bookkeeping. A capture is dropped only when an earlier result
  // is still waiting and is not being taken this very cycle; a capture that
  // coincides with a transfer simply replaces the outgoing value.
  assign w_transfer     = r_periodValid & period_ready;
  assign w_overrunEvent = w_capture & r_periodValid & ~period_ready;
  assign w_load         = w_capture & ~w_overrunEvent;

  // Sample the measured signal once so edges can be detected; cleared by
  // reset so a pulse already high after reset shows up as a fresh edge.
  always_ff @(posedge Origin_Clock) begin
    if (reset) begin
      r_pulseQ <= 1'b0;
    end else begin
      r_pulseQ <= pulse;
    end
  end

  // State and period counter registers. Reset abandons any count in
  // progress, so the first edge afterwards can only re-arm.
  always_ff @(posedge Origin_Clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Next-state and counter logic. Dropping enable overrides everything and
  // parks the meter in IDLE. In MEASURE an edge always wins over saturation,
  // so an edge arriving exactly when the counter reaches its maximum still
  // yields that maximum as a valid period instead of a timeout. The counter
  // restarts at 1 on an edge because the edge cycle itself is the first
  // cycle of the next period.
  always_comb begin
    w_stateNext    = r_state;
    w_countNext    = r_count;
    w_capture      = 1'b0;
    w_timeoutEvent = 1'b0;
    if (!enable) begin
      w_stateNext = IDLE;
      w_countNext = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_countNext = '0;
          w_stateNext = ARM;
        end
        ARM: begin
          if (w_rise) begin
            w_countNext = CountOne;
            w_stateNext = MEASURE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            w_capture   = 1'b1;
            w_countNext = CountOne;
          end else if (r_count == CountMax) begin
            w_timeoutEvent = 1'b1;
            w_countNext    = '0;
            w_stateNext    = ARM;
          end else begin
            w_countNext = r_count + CountOne;
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_countNext = '0;
        end
      endcase
    end
  end

  // Result register and its valid flag. The period only changes on a load,
  // so it stays stable for as long as valid is high and the consumer has
  // not yet taken it. Enable does not touch these; results survive idling.
  always_ff @(posedge Origin_Clock) begin
    if (reset) begin
      r_period      <= '0;
      r_periodValid <= 1'b0;
    end else begin
      if (w_load) begin
        r_period      <= r_count;
        r_periodValid <= 1'b1;
      end else if (w_transfer) begin
        r_periodValid <= 1'b0;
      end
    end
  end

  // Sticky flags. A new event in the same cycle as a clear request wins,
  // so an event is never lost to a clear that was aimed at an older one.
  always_ff @(posedge Origin_Clock) begin
    if (reset) begin
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_timeout <= w_timeoutEvent | (r_timeout & ~clear_flags);
      r_overrun <= w_overrunEvent | (r_overrun & ~clear_flags);
    end
  end

  assign period       = r_period;
  assign period_valid = r_periodValid;
  assign locked       = (r_state == MEASURE);
  assign timeout      = r_timeout;
  assign overrun      = r_overrun;

endmodule
